// File: rtl/option_queue_if.sv
// option_queue_if: Option input word, pop strobe and head/status outputs (drop_count_o only with OPTION_QUEUE_DROP_COUNT_EN)
interface option_queue_if #(parameter int W = 16, parameter int DEPTH = 4);
  logic [W:0] in_i;
  logic pop_i;
  logic [W:0] output__;
  logic [$clog2(DEPTH):0] count_o;
  logic full_o;
`ifdef OPTION_QUEUE_DROP_COUNT_EN
  logic [15:0] drop_count_o;
  modport master (output in_i, pop_i, input output__, count_o, full_o, drop_count_o);
  modport slave (input in_i, pop_i, output output__, count_o, full_o, drop_count_o);
`else
  modport master (output in_i, pop_i, input output__, count_o, full_o);
  modport slave (input in_i, pop_i, output output__, count_o, full_o);
`endif
endinterface

// File: rtl/option_queue.sv
// option_queue: circular queue of Some payloads with Option-word head; OPTION_QUEUE_DROP_COUNT_EN adds a saturating drop counter
module option_queue #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input logic clk_i,
  input logic rst_n_i,
  option_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic full, pop_ok, push_req, push_ok;
  always_comb begin
    full = cnt_q == CW'(DEPTH);
    push_req = !q.in_i[W];
    pop_ok = q.pop_i && cnt_q != '0;
    push_ok = push_req && (!full || pop_ok);
    wp_d = push_ok ? wp_q + 1'b1 : wp_q;
    rp_d = pop_ok ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    q.output__ = cnt_q == '0 ? {1'b1, {W{1'b0}}} : {1'b0, mem_q[rp_q]};
    q.count_o = cnt_q;
    q.full_o = full;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_n_i && push_ok) mem_q[wp_q] <= q.in_i[W-1:0];
  end
`ifdef OPTION_QUEUE_DROP_COUNT_EN
  logic [15:0] drop_q, drop_d;
  always_comb begin
    drop_d = (push_req && !push_ok && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    q.drop_count_o = drop_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) drop_q <= '0;
    else drop_q <= drop_d;
  end
`endif
endmodule

// File: tb/tb_option_queue.sv
// tb_option_queue: directed stimulus, queue-based reference model checked every cycle, plus literal checkpoints
module tb_option_queue;
  localparam int W = 16;
  localparam int DEPTH = 4;
  localparam logic [W:0] NONE = 17'h10000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  bit en = 1'b0;
  logic [W-1:0] mq [$];
  int mdrop = 0;
  bit m_pop, m_push;
  option_queue_if #(.W(W), .DEPTH(DEPTH)) bus ();
  option_queue #(.W(W), .DEPTH(DEPTH)) dut (.clk_i(clk), .rst_n_i(rst_n), .q(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] some(input int v);
    return {1'b0, 16'(v)};
  endfunction

  // Reference: an unbounded queue capped at DEPTH; pop is applied first so a full push+pop fits
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      mdrop = 0;
    end else begin
      m_pop = bus.pop_i && mq.size() > 0;
      m_push = !bus.in_i[W];
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back(bus.in_i[W-1:0]);
        else if (mdrop < 65535) mdrop++;
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("m_head", 32'(bus.output__), mq.size() > 0 ? 32'({1'b0, mq[0]}) : 32'(NONE));
      chk("m_count", 32'(bus.count_o), 32'(mq.size()));
      chk("m_full", 32'(bus.full_o), 32'(mq.size() == DEPTH));
`ifdef OPTION_QUEUE_DROP_COUNT_EN
      chk("m_drop", 32'(bus.drop_count_o), 32'(mdrop));
`endif
    end
  end

  task automatic step(input logic r, input logic [W:0] d, input logic p);
    rst_n = r;
    bus.in_i = d;
    bus.pop_i = p;
    @(negedge clk);
  endtask

  initial begin
    bus.in_i = NONE;
    bus.pop_i = 1'b0;
    @(negedge clk);
    step(0, NONE, 0);
    step(0, NONE, 0);
    en = 1'b1;
    step(1, NONE, 0);
    chk("idle_head", 32'(bus.output__), 32'h10000);
    chk("idle_count", 32'(bus.count_o), 0);
    chk("idle_full", 32'(bus.full_o), 0);
    step(1, some(123), 0);
    chk("p123_head", 32'(bus.output__), 32'h0007B);
    chk("p123_count", 32'(bus.count_o), 1);
    step(1, {1'b1, 16'hBEEF}, 0);
    chk("none_keeps", 32'(bus.count_o), 1);
    step(1, NONE, 1);
    chk("pop_empty_head", 32'(bus.output__), 32'h10000);
    for (int i = 1; i <= 5; i++) step(1, some(i), 0);
    chk("fill_full", 32'(bus.full_o), 1);
    chk("fill_count", 32'(bus.count_o), 4);
`ifdef OPTION_QUEUE_DROP_COUNT_EN
    chk("fill_drop", 32'(bus.drop_count_o), 1);
`endif
    for (int i = 1; i <= 4; i++) begin
      chk("drain_head", 32'(bus.output__), 32'(i));
      step(1, NONE, 1);
    end
    chk("drain_none", 32'(bus.output__), 32'h10000);
    step(1, NONE, 1);
    chk("underflow_count", 32'(bus.count_o), 0);
    for (int i = 1; i <= 4; i++) step(1, some(i), 0);
    step(1, some(9), 1);
    chk("fullpp_count", 32'(bus.count_o), 4);
    for (int i = 0; i < 4; i++) begin
      chk("fullpp_head", 32'(bus.output__), i < 3 ? 32'(i + 2) : 32'd9);
      step(1, NONE, 1);
    end
    step(1, some(7), 1);
    chk("emptypp_count", 32'(bus.count_o), 1);
    chk("emptypp_head", 32'(bus.output__), 32'd7);
    for (int i = 0; i < 10; i++) begin
      chk("wrap_head", 32'(bus.output__), i == 0 ? 32'd7 : 32'(9 + i));
      step(1, some(10 + i), 1);
    end
    chk("wrap_last", 32'(bus.output__), 32'd19);
    chk("wrap_count", 32'(bus.count_o), 1);
    step(1, NONE, 1);
    for (int i = 0; i < 3; i++) step(1, some(30 + i), 0);
    chk("pre_rst_count", 32'(bus.count_o), 3);
    step(0, some(42), 1);
    chk("rst_count", 32'(bus.count_o), 0);
    chk("rst_head", 32'(bus.output__), 32'h10000);
    step(1, some(5), 0);
    chk("post_rst_head", 32'(bus.output__), 32'd5);
    step(1, some(6), 1);
    step(1, NONE, 0);
    chk("post_rst_next", 32'(bus.output__), 32'd6);
    en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/option_queue.md
# option_queue

Buffering stage directly downstream of the Option-producing unit: accepts one `Option<uint W>` word per cycle, stores only `Some` payloads in a small circular queue, and presents the oldest stored payload as an `Option` word to the next stage, which removes it with a pop strobe. It absorbs bursts of valid samples and discards `None` gaps.

## Interface
Parameters:
- `W`, 16: payload width; Option words are W+1 bits.
- `DEPTH`, 4: queue entries; power of two, at least 2.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `in_i`  in  W+1  Option word. Bit W is the tag (0 = Some, 1 = None); bits W-1:0 are the payload, ignored when tag = 1.
- `pop_i`  in  1  consumer removes the current head this cycle.
- `output__`  out  W+1  head as an Option word: `{1'b0, head}` when non-empty, `{1'b1, W'b0}` when empty.
- `count_o`  out  $clog2(DEPTH)+1  number of stored entries.
- `full_o`  out  1  count_o == DEPTH.
- `drop_count_o`  out  16  present only with the configuration macro (see Configuration).

## Operation
- Storage: DEPTH x W register array, write pointer `wp`, read pointer `rp`, each $clog2(DEPTH) bits, wrapping modulo DEPTH, plus the count register.
- Push request: `in_i[W] == 0`. Pop request: `pop_i == 1`.
- Pop accepted iff pop request and count > 0; `rp` advances by 1.
- Push accepted iff push request and either count < DEPTH, or count == DEPTH and a pop is accepted in the same cycle. The payload is written at `wp`, and `wp` advances by 1.
- Push while full without an accepted pop: payload is discarded and the state is unchanged.
- Pop while empty: ignored. No fall-through. A push and a pop on an empty queue results in count = 1 and leaves the pushed value at the head.
- count next = count + accepted push - accepted pop. It never exceeds DEPTH and never goes below 0.
- `None` words (tag 1) never modify state, whatever their payload bits are.
- `output__` and `full_o` are combinational decodes of the registered state (`rp`, array, count). They do not depend combinationally on `in_i` or `pop_i`.
- Reset (`rst_n_i == 0` at a rising edge): `wp = rp = count = 0`, giving `output__ = {1'b1, W'b0}`, `count_o = 0`, `full_o = 0`. Array contents are not reset. Reset takes priority over any simultaneous push or pop. Reset in the middle of a burst discards all stored entries.

## Timing
- Push-to-visible latency: 1 cycle. A Some word present at edge N appears on `output__` after edge N if the queue was empty.
- Pop effect: visible after the edge at which it is sampled. The next head, or None, appears in the same cycle.
- Throughput: one push and one pop per cycle sustained, including at full and at empty.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. FIFO order is preserved across the wrap.
- The first operation after reset deassertion is accepted in the first cycle in which `rst_n_i == 1`.

## Configuration
- Macro: `OPTION_QUEUE_DROP_COUNT_EN`.
- Defined: port `drop_count_o` exists. It is a 16-bit counter that increments by 1 for each discarded push (push request while full, no accepted pop). It saturates at 16'hFFFF and is cleared to 0 by reset.
- Undefined: the port and the counter are absent. Discarded pushes are silently lost and all other behaviour is identical.

## Test plan
- Reset, then idle with `in_i = {1'b1, 16'h0}` -> `output__ = 17'h10000`, `count_o = 0`, `full_o = 0`.
- Push Some 123 for one cycle, then None -> next cycle `output__ = {1'b0, 16'd123}` and `count_o = 1`. Pop once -> `output__ = 17'h10000`.
- Push 1, 2, 3, 4 (DEPTH 4), then 5 with no pop -> `full_o = 1`; pops return 1, 2, 3, 4 then None. With the macro, `drop_count_o = 1`.
- Full queue, then a simultaneous push of 9 and a pop -> count stays 4; pops return 2, 3, 4, 9.
- Empty queue, then a simultaneous push of 7 and a pop -> count 1, head 7. Afterwards, 10 cycles of push+pop with values 10..19 -> heads 7, 10, 11, ... in order across the pointer wrap.
- Push 3 entries, then assert `rst_n_i = 0` for one cycle while pushing 42 -> count 0, `output__` None. A later push of 5 appears as head 5.
